// File: rtl/bundle_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bundle_packer_pkg
// Brief    : Shared types and helpers for the bundle packer and slowdown stage.
// Revision : 1.0 - initial release
// ============================================================================
package bundle_packer_pkg;

   // FILL/HOLD encodings, shared with the slowdown stage
   localparam logic [0:0] c_FILL_ENC = 1'b0;
   localparam logic [0:0] c_HOLD_ENC = 1'b1;

   typedef enum logic [0:0] {
      ST_FILL = c_FILL_ENC,
      ST_HOLD = c_HOLD_ENC
   } bp_state_e;

   // Bit offset of bundle slot `slot` for a control word `bw` bits wide
   function automatic int slot_lsb(input int bw, input int slot);
      return bw * slot;
   endfunction

endpackage : bundle_packer_pkg
`default_nettype wire

// File: rtl/bundle_packer_bin2onehot.sv
`default_nettype none
// ============================================================================
// Module   : bundle_packer_bin2onehot
// Brief    : Binary index to one-hot decoder (inverse of one2bin).
// Revision : 1.0 - initial release
// ============================================================================
module bundle_packer_bin2onehot #(
   parameter int BIN_W = 2,
   parameter int OH_W  = 2
) (
   input  logic [BIN_W-1:0] i_bin,
   output logic [OH_W-1:0]  o_onehot
);

   // One output bit per index value; out-of-range indices decode to zero
   generate
      for (genvar i = 0; i < OH_W; i++) begin : g_oh
         assign o_onehot[i] = (i_bin == BIN_W'(i));
      end
   endgenerate

endmodule : bundle_packer_bin2onehot
`default_nettype wire

// File: rtl/bundle_packer.sv
`default_nettype none
// ============================================================================
// Module   : bundle_packer
// Brief    : Packs a serial stream of control words into a NUM_FETCH-slot
//            bundle with a contiguous, lowest-first valid mask.
// Revision : 1.0 - initial release
// ============================================================================
module bundle_packer
   import bundle_packer_pkg::*;
#(
   parameter int NUM_FETCH    = 2,
   parameter int BUFFER_WIDTH = 155
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [BUFFER_WIDTH-1:0]           in_data_i,
   input  logic                              in_last_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [BUFFER_WIDTH*NUM_FETCH-1:0] out_data_o,
   output logic [NUM_FETCH-1:0]              out_mask_o
);

   localparam int                CNT_W      = $clog2(NUM_FETCH + 1);
   localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(NUM_FETCH - 1);
   localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

   bp_state_e                         r_state;
   logic [CNT_W-1:0]                  r_cnt;
   logic [NUM_FETCH-1:0]              r_mask;
   logic [BUFFER_WIDTH*NUM_FETCH-1:0] r_data;

   bp_state_e                         w_state_n;
   logic [CNT_W-1:0]                  w_cnt_n;
   logic [NUM_FETCH-1:0]              w_mask_n;
   logic [BUFFER_WIDTH*NUM_FETCH-1:0] w_data_n;

   logic                              w_in_fire;
   logic                              w_out_fire;
   logic [NUM_FETCH-1:0]              w_slot_oh;

   // Ready is a pure function of state and consumer ready, never of in_valid_i
   assign in_ready_o  = (r_state == ST_FILL) | ((r_state == ST_HOLD) & out_ready_i);
   assign out_valid_o = (r_state == ST_HOLD);
   assign out_data_o  = r_data;
   assign out_mask_o  = r_mask;

   assign w_in_fire   = in_valid_i & in_ready_o;
   assign w_out_fire  = out_valid_o & out_ready_i;

   // Slot write-enable decoded from the fill count
   bundle_packer_bin2onehot #(
      .BIN_W (CNT_W),
      .OH_W  (NUM_FETCH)
   ) u_slot_dec (
      .i_bin    (r_cnt),
      .o_onehot (w_slot_oh)
   );

   // Next-state logic: flush first, then the FILL/HOLD handshake rules
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_mask_n  = r_mask;
      w_data_n  = r_data;

      if (flush_i) begin
         w_state_n = ST_FILL;
         w_cnt_n   = '0;
         w_mask_n  = '0;
         w_data_n  = '0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_in_fire) begin
                  // First word of a bundle also zeroes the remaining slots
                  for (int i = 0; i < NUM_FETCH; i++) begin
                     if (w_slot_oh[i]) begin
                        w_data_n[slot_lsb(BUFFER_WIDTH, i) +: BUFFER_WIDTH] = in_data_i;
                     end else if (r_cnt == '0) begin
                        w_data_n[slot_lsb(BUFFER_WIDTH, i) +: BUFFER_WIDTH] = '0;
                     end
                  end
                  w_mask_n = r_mask | w_slot_oh;
                  if ((r_cnt == c_CNT_LAST) || in_last_i) begin
                     w_state_n = ST_HOLD;
                     w_cnt_n   = '0;
                  end else begin
                     w_cnt_n   = r_cnt + c_CNT_ONE;
                  end
               end
            end

            ST_HOLD: begin
               if (w_out_fire) begin
                  if (w_in_fire) begin
                     // Back-to-back: new word opens the next bundle in slot 0
                     w_data_n                 = '0;
                     w_data_n[BUFFER_WIDTH-1:0] = in_data_i;
                     w_mask_n                 = NUM_FETCH'(1);
                     if ((NUM_FETCH == 1) || in_last_i) begin
                        w_state_n = ST_HOLD;
                        w_cnt_n   = '0;
                     end else begin
                        w_state_n = ST_FILL;
                        w_cnt_n   = c_CNT_ONE;
                     end
                  end else begin
                     // Data left in place; the cleared mask marks it stale
                     w_state_n = ST_FILL;
                     w_cnt_n   = '0;
                     w_mask_n  = '0;
                  end
               end
            end

            default: begin
               w_state_n = ST_FILL;
               w_cnt_n   = '0;
               w_mask_n  = '0;
               w_data_n  = '0;
            end
         endcase
      end
   end

   // State, count, mask and slot data registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FILL;
         r_cnt   <= '0;
         r_mask  <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_mask  <= w_mask_n;
         r_data  <= w_data_n;
      end
   end

endmodule : bundle_packer
`default_nettype wire
